param_stack_alu: RTL and testbench

PARAM_STACK_ALU -- requirements
Module: param_stack_alu

---
 rtl/param_stack_alu.sv | 216 +++++++++++++++++++++
 tb/tb_param_stack_alu.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/param_stack_alu.sv
// Parameterised signed RPN stack ALU with an iterative shift-add multiplier.
// Optional build macro PARAM_STACK_ALU_SAT_EN: saturate ADD/SUB/MUL overflow instead of wrapping.
module param_stack_alu #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [2:0]                 opcode,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic                       ovf_sticky
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_e;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000, OP_MUL  = 3'b001, OP_SUB  = 3'b010, OP_DUP = 3'b011,
        OP_PUSH = 3'b100, OP_POP  = 3'b101, OP_SWAP = 3'b110, OP_CLR = 3'b111
    } op_e;
    typedef enum logic [1:0] {E_NONE, E_UNDER, E_FULL, E_OVF} err_e;
    typedef enum logic [2:0] {A_NONE, A_PUSH, A_POP, A_REPL2, A_SWAP, A_CLR} act_e;

    // Shift-register stack: entry 0 is always the top, so no count-based indexing is needed.
    logic [WIDTH-1:0] stack [DEPTH];

    state_e           state, state_d;
    act_e             act;
    err_e             code, code_q;
    logic             done, ovf, mul_start;
    logic [WIDTH-1:0] res, top, nxt;
    logic [WIDTH:0]   add_ext, sub_ext;
    logic [WIDTH-1:0] add_res, sub_res, mul_res;
    logic             add_ovf, sub_ovf, mul_ovf;
    logic [WIDTH-1:0] mag_a, mag_b;

    logic [2*WIDTH-1:0] mul_acc, mul_mcand, mul_prod;
    logic [WIDTH-1:0]   mul_mplier;
    logic               mul_neg;
    logic [IW-1:0]      mul_iter;

    assign top      = stack[0];
    assign nxt      = stack[1];
    assign op_ready = (state == IDLE);
    assign dout     = (count == '0) ? '0 : top;
    assign err_code = code_q;

    assign add_ext = {nxt[WIDTH-1], nxt} + {top[WIDTH-1], top};
    assign sub_ext = {nxt[WIDTH-1], nxt} - {top[WIDTH-1], top};
    assign add_ovf = add_ext[WIDTH] ^ add_ext[WIDTH-1];
    assign sub_ovf = sub_ext[WIDTH] ^ sub_ext[WIDTH-1];

    assign mag_a    = nxt[WIDTH-1] ? -nxt : nxt;
    assign mag_b    = top[WIDTH-1] ? -top : top;
    assign mul_prod = mul_neg ? -mul_acc : mul_acc;
    assign mul_ovf  = !((&mul_prod[2*WIDTH-1:WIDTH-1]) || (~|mul_prod[2*WIDTH-1:WIDTH-1]));

`ifdef PARAM_STACK_ALU_SAT_EN
    assign add_res = add_ovf ? (add_ext[WIDTH] ? SMIN : SMAX) : add_ext[WIDTH-1:0];
    assign sub_res = sub_ovf ? (sub_ext[WIDTH] ? SMIN : SMAX) : sub_ext[WIDTH-1:0];
    assign mul_res = mul_ovf ? (mul_neg ? SMIN : SMAX) : mul_prod[WIDTH-1:0];
`else
    assign add_res = add_ext[WIDTH-1:0];
    assign sub_res = sub_ext[WIDTH-1:0];
    assign mul_res = mul_prod[WIDTH-1:0];
`endif

    always_comb begin
        state_d   = state;
        act       = A_NONE;
        res       = '0;
        done      = 1'b0;
        code      = E_NONE;
        ovf       = 1'b0;
        mul_start = 1'b0;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    done = 1'b1;
                    case (opcode)
                        OP_ADD, OP_SUB: begin
                            if (count < CW'(2)) begin
                                code = E_UNDER;
                            end else begin
                                act = A_REPL2;
                                res = (opcode == OP_ADD) ? add_res : sub_res;
                                ovf = (opcode == OP_ADD) ? add_ovf : sub_ovf;
                                if (ovf) code = E_OVF;
                            end
                        end
                        OP_MUL: begin
                            if (count < CW'(2)) begin
                                code = E_UNDER;
                            end else begin
                                done      = 1'b0;
                                mul_start = 1'b1;
                                state_d   = MUL_RUN;
                            end
                        end
                        OP_DUP: begin
                            if (count == '0)              code = E_UNDER;
                            else if (count == CW'(DEPTH)) code = E_FULL;
                            else begin
                                act = A_PUSH;
                                res = top;
                            end
                        end
                        OP_PUSH: begin
                            if (count == CW'(DEPTH)) code = E_FULL;
                            else begin
                                act = A_PUSH;
                                res = din;
                            end
                        end
                        OP_POP: begin
                            if (count == '0) code = E_UNDER;
                            else             act  = A_POP;
                        end
                        OP_SWAP: begin
                            if (count < CW'(2)) code = E_UNDER;
                            else                act  = A_SWAP;
                        end
                        default: act = A_CLR;
                    endcase
                end
            end
            MUL_RUN: begin
                if (mul_iter == IW'(WIDTH-1)) state_d = MUL_DONE;
            end
            MUL_DONE: begin
                done    = 1'b1;
                act     = A_REPL2;
                res     = mul_res;
                ovf     = mul_ovf;
                if (mul_ovf) code = E_OVF;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            err        <= 1'b0;
            code_q     <= E_NONE;
            ovf_sticky <= 1'b0;
        end else begin
            state <= state_d;
            err   <= done && (code != E_NONE);
            if (done) code_q <= code;
            case (act)
                A_PUSH:         count <= count + CW'(1);
                A_POP, A_REPL2: count <= count - CW'(1);
                A_CLR:          count <= '0;
                default:        count <= count;
            endcase
            if (act == A_CLR) ovf_sticky <= 1'b0;
            else if (ovf)     ovf_sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        case (act)
            A_PUSH: begin
                stack[0] <= res;
                for (int unsigned i = 1; i < DEPTH; i++) stack[i] <= stack[i-1];
            end
            A_POP: begin
                for (int unsigned i = 0; i < DEPTH-1; i++) stack[i] <= stack[i+1];
            end
            A_REPL2: begin
                stack[0] <= res;
                for (int unsigned i = 1; i < DEPTH-1; i++) stack[i] <= stack[i+1];
            end
            A_SWAP: begin
                stack[0] <= stack[1];
                stack[1] <= stack[0];
            end
            default: ;
        endcase
    end

    // Operands stay on the stack during the multiply; only magnitudes and the sign are captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_neg    <= 1'b0;
            mul_iter   <= '0;
        end else if (mul_start) begin
            mul_acc    <= '0;
            mul_mcand  <= {{WIDTH{1'b0}}, mag_a};
            mul_mplier <= mag_b;
            mul_neg    <= nxt[WIDTH-1] ^ top[WIDTH-1];
            mul_iter   <= '0;
        end else if (state == MUL_RUN) begin
            if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
            mul_mcand  <= {mul_mcand[2*WIDTH-2:0], 1'b0};
            mul_mplier <= {1'b0, mul_mplier[WIDTH-1:1]};
            mul_iter   <= mul_iter + IW'(1);
        end
    end

endmodule

// File: tb/tb_param_stack_alu.sv
// Scoreboard bench for param_stack_alu (WIDTH=32, DEPTH=4): stimulus queues expectations, monitor checks completions.
module tb_param_stack_alu;

    localparam logic [2:0] ADD = 3'b000, MUL = 3'b001, SUB = 3'b010, DUP = 3'b011;
    localparam logic [2:0] PUSH = 3'b100, POP = 3'b101, SWAP = 3'b110, CLR = 3'b111;

`ifdef PARAM_STACK_ALU_SAT_EN
    localparam logic [31:0] OVF_ADD = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_BIG = 32'h7FFF_FFFF;
    localparam logic [31:0] OVF_NEG = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] OVF_ADD = 32'h8000_0000;
    localparam logic [31:0] OVF_BIG = 32'h0000_0000;
    localparam logic [31:0] OVF_NEG = 32'h8000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  opcode = 3'b000;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [2:0]  count;
    logic        err;
    logic [1:0]  err_code;
    logic        ovf_sticky;

    param_stack_alu #(.WIDTH(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .din(din), .dout(dout), .count(count),
        .err(err), .err_code(err_code), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dout;
        logic [2:0]  count;
        logic        err;
        logic [1:0]  code;
        logic        sticky;
        int          busy;
    } exp_t;

    exp_t q[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [31:0] e_dout,
                         input int e_cnt, input logic e_err, input logic [1:0] e_code,
                         input logic e_st, input int e_busy, input bit hold);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!op_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!op_ready) begin
            chk("ready_timeout", 64'(op_ready), 64'd1);
            return;
        end
        e.dout = e_dout; e.count = 3'(e_cnt); e.err = e_err;
        e.code = e_code; e.sticky = e_st; e.busy = e_busy;
        q.push_back(e);
        op_valid = 1'b1;
        opcode   = op;
        din      = d;
        @(posedge clk);
        #1;
        if (hold) begin
            opcode = PUSH;
            din    = 32'd99;
            t = 0;
            while (t < 100) begin
                @(negedge clk);
                if (op_ready) break;
                t++;
            end
        end
        op_valid = 1'b0;
    endtask

    // Monitor: a completion is presented when op_ready is high after an accepted opcode.
    initial begin
        exp_t e;
        int   busy;
        forever begin
            @(posedge clk);
            if (!rst && op_valid && op_ready) begin
                busy = 0;
                @(negedge clk);
                while (!op_ready && busy < 200) begin
                    busy++;
                    @(negedge clk);
                end
                if (q.size() == 0) begin
                    chk("queue_empty", 64'd0, 64'd1);
                end else begin
                    e = q.pop_front();
                    chk("dout", 64'(dout), 64'(e.dout));
                    chk("count", 64'(count), 64'(e.count));
                    chk("err", 64'(err), 64'(e.err));
                    chk("err_code", 64'(err_code), 64'(e.code));
                    chk("ovf_sticky", 64'(ovf_sticky), 64'(e.sticky));
                    if (e.busy >= 0) chk("busy_cycles", 64'(busy), 64'(e.busy));
                end
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_sticky", 64'(ovf_sticky), 64'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(op_ready), 64'd1);

        // RPN expression; first MUL holds op_valid high throughout
        issue(PUSH, 32'd2,          32'd2,          1, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd3,          32'd3,          2, 0, 2'b00, 0, 0, 0);
        issue(MUL,  32'd0,          32'd6,          1, 0, 2'b00, 0, 33, 1);
        issue(PUSH, 32'd10,         32'd10,         2, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd4,          32'd4,          3, 0, 2'b00, 0, 0, 0);
        issue(ADD,  32'd0,          32'd14,         2, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd3,          32'd3,          3, 0, 2'b00, 0, 0, 0);
        issue(ADD,  32'd0,          32'd17,         2, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'hFFFF_FFEC,  32'hFFFF_FFEC,  3, 0, 2'b00, 0, 0, 0);
        issue(MUL,  32'd0,          32'hFFFF_FEAC,  2, 0, 2'b00, 0, 33, 0);
        issue(ADD,  32'd0,          32'hFFFF_FEB2,  1, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd6,          32'd6,          2, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd5,          32'd5,          3, 0, 2'b00, 0, 0, 0);
        issue(ADD,  32'd0,          32'd11,         2, 0, 2'b00, 0, 0, 0);
        issue(ADD,  32'd0,          32'hFFFF_FEBD,  1, 0, 2'b00, 0, 0, 0);
        issue(CLR,  32'd0,          32'd0,          0, 0, 2'b00, 0, 0, 0);

        // Full and underflow boundaries
        issue(PUSH, 32'd1,          32'd1,          1, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd2,          32'd2,          2, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd3,          32'd3,          3, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd4,          32'd4,          4, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd5,          32'd4,          4, 1, 2'b10, 0, 0, 0);
        issue(DUP,  32'd0,          32'd4,          4, 1, 2'b10, 0, 0, 0);
        issue(CLR,  32'd0,          32'd0,          0, 0, 2'b00, 0, 0, 0);
        issue(ADD,  32'd0,          32'd0,          0, 1, 2'b01, 0, 0, 0);
        issue(POP,  32'd0,          32'd0,          0, 1, 2'b01, 0, 0, 0);
        issue(PUSH, 32'd5,          32'd5,          1, 0, 2'b00, 0, 0, 0);
        issue(SWAP, 32'd0,          32'd5,          1, 1, 2'b01, 0, 0, 0);
        issue(MUL,  32'd0,          32'd5,          1, 1, 2'b01, 0, 0, 0);
        issue(DUP,  32'd0,          32'd5,          2, 0, 2'b00, 0, 0, 0);
        issue(POP,  32'd0,          32'd5,          1, 0, 2'b00, 0, 0, 0);
        issue(CLR,  32'd0,          32'd0,          0, 0, 2'b00, 0, 0, 0);

        // Arithmetic overflow and sticky flag
        issue(PUSH, 32'h7FFF_FFFF,  32'h7FFF_FFFF,  1, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd1,          32'd1,          2, 0, 2'b00, 0, 0, 0);
        issue(ADD,  32'd0,          OVF_ADD,        1, 1, 2'b11, 1, 0, 0);
        issue(PUSH, 32'd1,          32'd1,          2, 0, 2'b00, 1, 0, 0);
        issue(CLR,  32'd0,          32'd0,          0, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'h0001_0000,  32'h0001_0000,  1, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'h0001_0000,  32'h0001_0000,  2, 0, 2'b00, 0, 0, 0);
        issue(MUL,  32'd0,          OVF_BIG,        1, 1, 2'b11, 1, 33, 0);
        issue(CLR,  32'd0,          32'd0,          0, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'hFFFF_0000,  32'hFFFF_0000,  1, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'h0000_8000,  32'h0000_8000,  2, 0, 2'b00, 0, 0, 0);
        issue(MUL,  32'd0,          32'h8000_0000,  1, 0, 2'b00, 0, 33, 0);
        issue(PUSH, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  2, 0, 2'b00, 0, 0, 0);
        issue(MUL,  32'd0,          OVF_NEG,        1, 1, 2'b11, 1, 33, 0);

        // SWAP then SUB, then CLR drops the sticky flag
        issue(PUSH, 32'd1,          32'd1,          2, 0, 2'b00, 1, 0, 0);
        issue(PUSH, 32'd2,          32'd2,          3, 0, 2'b00, 1, 0, 0);
        issue(SWAP, 32'd0,          32'd1,          3, 0, 2'b00, 1, 0, 0);
        issue(SUB,  32'd0,          32'd1,          2, 0, 2'b00, 1, 0, 0);
        issue(CLR,  32'd0,          32'd0,          0, 0, 2'b00, 0, 0, 0);

        // Reset during a multiply: monitor sees the reset state as the outcome
        issue(PUSH, 32'd7,          32'd7,          1, 0, 2'b00, 0, 0, 0);
        issue(PUSH, 32'd9,          32'd9,          2, 0, 2'b00, 0, 0, 0);
        issue(MUL,  32'd0,          32'd0,          0, 0, 2'b00, 0, -1, 0);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 64'(op_ready), 64'd1);
        chk("abort_count", 64'(count), 64'd0);
        chk("abort_dout", 64'(dout), 64'd0);
        issue(PUSH, 32'd3,          32'd3,          1, 0, 2'b00, 0, 0, 0);

        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
